multi_pulse_generator: RTL

//   N-channel, fully synchronous pulse generator. Each channel detects a selectable edge (rise/fall/both) on its input
//   and drives a registered output pulse of programmable length, with optional retrigger. Replaces the latch-based

---
 rtl/pulse_gen_pkg.sv | 33 +++
 rtl/pulse_gen_channel.sv | 101 ++++++++++
 rtl/multi_pulse_generator.sv | 67 ++++++
 3 files changed

// File: rtl/pulse_gen_pkg.sv
// Shared constants and types for the multi-channel pulse generator.
// PULSE_GEN_SYNC_EN (optional define) adds a 2-flop input synchroniser per channel.
package pulse_gen_pkg;

  localparam logic [1:0] EDGE_NONE = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;

`ifdef PULSE_GEN_SYNC_EN
  localparam int SYNC_STAGES = 2;
`else
  localparam int SYNC_STAGES = 0;
`endif

  typedef enum logic {
    CH_IDLE  = 1'b0,
    CH_PULSE = 1'b1
  } ch_state_e;

  function automatic logic edge_hit(input logic [1:0] mode, input logic cur, input logic prev);
    logic hit;
    hit = 1'b0;
    case (mode)
      EDGE_RISE: hit = cur & ~prev;
      EDGE_FALL: hit = ~cur & prev;
      EDGE_BOTH: hit = cur ^ prev;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/pulse_gen_channel.sv
// One pulse channel: optional synchroniser, edge detector, pulse FSM, down-counter, sticky miss flag.
// Synchroniser present only when PULSE_GEN_SYNC_EN is defined.
//
// state    | meaning
// CH_IDLE  | output low, waiting for a selected edge
// CH_PULSE | output high, cnt_q cycles remain after the current one
module pulse_gen_channel
  import pulse_gen_pkg::*;
#(
  parameter int LEN_BITS = 8
) (
  input  logic                clk,
  input  logic                nReset,
  input  logic                in_raw,
  input  logic [1:0]          edge_sel,
  input  logic [LEN_BITS-1:0] cnt_load,
  input  logic                primed,
  input  logic                retrig,
  input  logic                clr_missed,
  output logic                out,
  output logic                busy,
  output logic                missed
);

  logic                in_s;
  logic                hist_q, hist_d;
  ch_state_e           state_q, state_d;
  logic [LEN_BITS-1:0] cnt_q, cnt_d;
  logic                out_q, out_d;
  logic                missed_q, missed_d;
  logic                trig;
  logic                miss_evt;

`ifdef PULSE_GEN_SYNC_EN
  logic [1:0] sync_q, sync_d;

  assign sync_d = {sync_q[0], in_raw};
  assign in_s   = sync_q[1];

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) sync_q <= '0;
    else         sync_q <= sync_d;
  end
`else
  assign in_s = in_raw;
`endif

  // History follows the input every cycle so enabling a channel never sees a stale edge.
  assign hist_d = in_s;
  assign trig   = primed & edge_hit(edge_sel, in_s, hist_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    miss_evt = 1'b0;
    case (state_q)
      CH_IDLE: begin
        if (trig) begin
          state_d = CH_PULSE;
          cnt_d   = cnt_load;
        end
      end
      CH_PULSE: begin
        if (cnt_q == '0) begin
          if (trig) cnt_d   = cnt_load;
          else      state_d = CH_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (trig) begin
            if (retrig) cnt_d    = cnt_load;
            else        miss_evt = 1'b1;
          end
        end
      end
      default: state_d = CH_IDLE;
    endcase
    out_d    = (state_d == CH_PULSE);
    missed_d = (missed_q & ~clr_missed) | miss_evt;
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      hist_q   <= 1'b0;
      state_q  <= CH_IDLE;
      cnt_q    <= '0;
      out_q    <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      hist_q   <= hist_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      missed_q <= missed_d;
    end
  end

  assign out    = out_q;
  assign busy   = out_q;
  assign missed = missed_q;

endmodule

// File: rtl/multi_pulse_generator.sv
// N-channel synchronous pulse generator; shares priming, pulse length and miss-clear across channels.
// Define PULSE_GEN_SYNC_EN to insert a 2-flop synchroniser on every input bit.
module multi_pulse_generator
  import pulse_gen_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int LEN_BITS = 8
) (
  input  logic                  clk,
  input  logic                  nReset,
  input  logic [CHANNELS-1:0]   in,
  input  logic [2*CHANNELS-1:0] edge_sel,
  input  logic [LEN_BITS-1:0]   pulse_len,
  input  logic [CHANNELS-1:0]   retrig,
  input  logic                  clr_missed,
  output logic [CHANNELS-1:0]   out,
  output logic [CHANNELS-1:0]   busy,
  output logic [CHANNELS-1:0]   missed
);

  // Detection waits until the edge history holds a real sample that came through any synchroniser.
  localparam logic [1:0] PRIME_WAIT = 2'(SYNC_STAGES);

  logic                primed_q, primed_d;
  logic [1:0]          prime_cnt_q, prime_cnt_d;
  logic [LEN_BITS-1:0] cnt_load;

  assign cnt_load = (pulse_len == '0) ? '0 : pulse_len - 1'b1;

  always_comb begin
    primed_d    = primed_q;
    prime_cnt_d = prime_cnt_q;
    if (!primed_q) begin
      if (prime_cnt_q == PRIME_WAIT) primed_d    = 1'b1;
      else                           prime_cnt_d = prime_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      primed_q    <= 1'b0;
      prime_cnt_q <= '0;
    end else begin
      primed_q    <= primed_d;
      prime_cnt_q <= prime_cnt_d;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    pulse_gen_channel #(
      .LEN_BITS(LEN_BITS)
    ) u_ch (
      .clk       (clk),
      .nReset    (nReset),
      .in_raw    (in[c]),
      .edge_sel  (edge_sel[2*c +: 2]),
      .cnt_load  (cnt_load),
      .primed    (primed_q),
      .retrig    (retrig[c]),
      .clr_missed(clr_missed),
      .out       (out[c]),
      .busy      (busy[c]),
      .missed    (missed[c])
    );
  end

endmodule
